// File: rtl/rst_sequencer.sv
// Reset sequencer: holds all downstream domains in reset, then releases them one
// at a time; merges soft-reset/watchdog requests and keeps a sticky reset cause.
module rst_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   sysresetreq_i,
  input  logic                   wdog_reset_i,
  input  logic                   cause_clr_i,
  output logic [NUM_DOMAINS-1:0] domain_reset_n_o,
  output logic                   reset_done_o,
  output logic [2:0]             reset_cause_o
);

  // state      | meaning
  // ST_HOLD    | all domains in reset, counting the minimum hold time
  // ST_RELEASE | releasing domains idx..NUM_DOMAINS-1, one per STAGE_DELAY
  // ST_RUN     | every domain released; reset_done follows one cycle later

  localparam int                   IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAGE_LAST = CNT_WIDTH'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic [2:0]             cause_q, cause_d;
  logic                   req;

  assign req = sysresetreq_i | wdog_reset_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= 3'b001;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    // A request on the same edge as a clear keeps its own bit set.
    cause_d = (cause_clr_i ? 3'b000 : cause_q) | {wdog_reset_i, sysresetreq_i, 1'b0};

    if (req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          done_d = 1'b0;
          if (cnt_q == HOLD_LAST) begin
            dom_d[0] = 1'b1;
            cnt_d    = '0;
            idx_d    = IDX_W'(1);
            state_d  = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (idx_q == IDX_W'(i)) dom_d[i] = 1'b1;
            end
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_RUN: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  assign domain_reset_n_o = dom_q;
  assign reset_done_o     = done_q;
  assign reset_cause_o    = cause_q;

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Reset sequencer in the RCC that sits directly downstream of the two-stage reset synchronizer and consumes its synchronized, active-low reset. It holds every downstream domain in reset for a minimum time, then releases the domain resets one at a time with a fixed spacing. It also merges CPU soft-reset and watchdog reset requests into the same sequence, and keeps a sticky reset-cause register for software.

## Interface
- NUM_DOMAINS, 3: number of sequenced domain resets (≥1); domain 0 released first.
- HOLD_CYCLES, 8: minimum cycles all domains stay in reset after the last request/reset clears (≥1).
- STAGE_DELAY, 16: cycles between consecutive domain releases (≥1).
- CNT_WIDTH, 8: counter width; must hold max(HOLD_CYCLES, STAGE_DELAY)-1.

- CLK  input  1  single system clock.
- RESET  input  1  asynchronous active-low reset, driven by the synchronizer's SYNC_RESET output.
- SYSRESETREQ  input  1  CPU soft-reset request, level, synchronous to CLK.
- WDOG_RESET  input  1  watchdog reset request, level, synchronous to CLK.
- CAUSE_CLR  input  1  one-cycle pulse; clears RESET_CAUSE.
- DOMAIN_RESET_N  output  NUM_DOMAINS  per-domain active-low resets.
- RESET_DONE  output  1  high when all domains are released and the FSM is in RUN.
- RESET_CAUSE  output  3  sticky cause bits: [0] power-on/RESET, [1] SYSRESETREQ, [2] WDOG_RESET.

## Operation
- States are HOLD, RELEASE and RUN. A counter `cnt` (CNT_WIDTH bits) and a domain index `idx` support them.
- `req` = SYSRESETREQ | WDOG_RESET.
- RESET low (asynchronous) forces the following values:
  - state=HOLD, cnt=0, idx=0;
  - DOMAIN_RESET_N=all 0, RESET_DONE=0, RESET_CAUSE=3'b001.
- HOLD:
  - If req is high, cnt is held at 0.
  - Otherwise cnt increments each edge.
  - At the edge where cnt==HOLD_CYCLES-1 and req is low: DOMAIN_RESET_N[0]←1, idx←1, cnt←0, state←RELEASE.
  - When NUM_DOMAINS==1, that edge goes to RUN instead, and RESET_DONE rises on the following edge.
- RELEASE:
  - cnt increments each edge.
  - At the edge where cnt==STAGE_DELAY-1: DOMAIN_RESET_N[idx]←1, cnt←0, idx←idx+1.
  - If idx was NUM_DOMAINS-1, state←RUN.
- RUN:
  - RESET_DONE←1 on the edge entering-plus-one, i.e. it registers one cycle after the last release.
  - Outputs stay stable while req is low.
- Request in any state (req high at an edge):
  - That edge applies: DOMAIN_RESET_N←all 0, RESET_DONE←0, cnt←0, idx←0, state←HOLD.
  - A request during RELEASE restarts the full sequence.
  - A request held high keeps the block in HOLD with the counter frozen at 0.
- Cause register:
  - At any edge with SYSRESETREQ high, bit1←1; with WDOG_RESET high, bit2←1. Both can set on the same edge.
  - CAUSE_CLR clears all three bits at that edge.
  - If CAUSE_CLR coincides with a request, the set wins for the requesting bit(s) and the other bits clear.
  - Bit0 is set only by RESET.
- Domain resets are monotonic within one sequence. Once released, a domain is re-asserted only by a request or by RESET.
- Every output is driven directly from a register, with no combinational path from input to output.

## Timing
- Edges are numbered from the first rising CLK edge with RESET high, which is edge 1. Assume no request.
  - Domain k is released at edge HOLD_CYCLES + k·STAGE_DELAY.
  - RESET_DONE rises at edge HOLD_CYCLES + (NUM_DOMAINS-1)·STAGE_DELAY + 1.
- Request latency: req sampled high at edge E means all DOMAIN_RESET_N are low and RESET_DONE is low after edge E.
  - If req falls before edge F (first edge where req is sampled low), domain 0 is released at edge F+HOLD_CYCLES-1.
  - The following releases keep the same spacing as above.
- RESET assertion mid-operation takes effect immediately and asynchronously.
- On RESET release, timing restarts at edge 1, and RESET_CAUSE reads 3'b001 regardless of prior contents.

## Test plan
- POR, defaults: release RESET, no requests → DOMAIN_RESET_N goes 000→001 at edge 8, 011 at edge 24, 111 at edge 40; RESET_DONE=1 at edge 41; RESET_CAUSE=001.
- Soft reset in RUN: SYSRESETREQ high for 3 cycles (sampled edges 100–102) → DOMAIN_RESET_N=000 and RESET_DONE=0 after edge 100; domain 0 released at edge 110, domain 2 at edge 142, RESET_DONE at edge 143; RESET_CAUSE=011.
- Watchdog during RELEASE: WDOG_RESET pulse at edge 30 (domains at 011) → 000 after edge 30; sequence restarts with domain 0 at edge 38; RESET_CAUSE bit2=1.
- Simultaneous requests plus clear: SYSRESETREQ, WDOG_RESET and CAUSE_CLR all high at one edge → RESET_CAUSE=110. A CAUSE_CLR pulse alone afterwards → RESET_CAUSE=000.
- Held request: WDOG_RESET high for 50 cycles → all domains stay 0 for the whole interval; release occurs HOLD_CYCLES-1 edges after the first low sample.
- Async reset mid-RELEASE: drop RESET between edges while DOMAIN_RESET_N=011 → outputs go to 000 / RESET_DONE=0 / cause=001 without waiting for a clock edge. Repeat with NUM_DOMAINS=1, HOLD_CYCLES=1, STAGE_DELAY=1 to cover the boundary parameter values.
